// File: rtl/bsg_manycore_pkg.sv
// rtl/bsg_manycore_pkg.sv - shared constants, types and packet-width helper for the cache packet arbiter
package bsg_manycore_pkg;

  localparam int bsg_cache_arb_clients_gp  = 2;
  localparam int bsg_cache_opcode_width_gp = 6;

  typedef logic [0:0] bsg_cache_arb_id_t;

  // Packet layout is {opcode, addr, data, byte mask}.
  function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
    return bsg_cache_opcode_width_gp + addr_width + data_width + data_width / 8;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small one-read one-write FIFO with registered occupancy count
module bsg_fifo_1r1w_small
  import bsg_manycore_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 1,
  localparam int count_w_lp = $clog2(els_p + 1),
  localparam int ptr_w_lp   = $clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [width_p-1:0]    mem_r [els_p];
  logic [ptr_w_lp-1:0]   wptr_r, rptr_r;
  logic [count_w_lp-1:0] count_r;
  logic                  push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_r == count_w_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= ptr_inc(wptr_r);
      if (pop)  rptr_r <= ptr_inc(rptr_r);
      unique case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_cache_pkt_arbiter.sv
// rtl/bsg_manycore_cache_pkt_arbiter.sv - two-client round-robin arbiter sharing one bsg_cache
// Optional macro BSG_MANYCORE_CACHE_ARB_FIXED_PRIO_EN: client 0 always wins ties.
module bsg_manycore_cache_pkt_arbiter
  import bsg_manycore_pkg::*;
#(
  parameter int cache_addr_width_p = 10,
  parameter int data_width_p       = 32,
  parameter int fifo_els_p         = 4,
  localparam int pkt_w_lp   = bsg_cache_pkt_width(cache_addr_width_p, data_width_p),
  localparam int clients_lp = bsg_cache_arb_clients_gp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [clients_lp-1:0][pkt_w_lp-1:0] cache_pkt_i,
  input  logic [clients_lp-1:0]              v_i,
  output logic [clients_lp-1:0]              ready_o,
  output logic [data_width_p-1:0]            data_o,
  output logic [clients_lp-1:0]              v_o,
  input  logic [clients_lp-1:0]              yumi_i,
  output logic [clients_lp-1:0]              v_we_o,
  output logic [pkt_w_lp-1:0]                cache_pkt_o,
  output logic                               cache_v_o,
  input  logic                               cache_ready_i,
  input  logic [data_width_p-1:0]            cache_data_i,
  input  logic                               cache_v_i,
  output logic                               cache_yumi_o,
  input  logic                               cache_v_we_i
);

  bsg_cache_arb_id_t last_r, tl_owner_r, grant, head;
  logic              full, empty, accept, resp_v;

  always_comb begin
    grant = bsg_cache_arb_id_t'(v_i[1]);
    if (&v_i) begin
`ifdef BSG_MANYCORE_CACHE_ARB_FIXED_PRIO_EN
      grant = '0;
`else
      grant = ~last_r;
`endif
    end
  end

  // Outputs are gated by reset so nothing leaks while reset is held.
  assign cache_v_o   = reset_n_i & (|v_i) & ~full;
  assign cache_pkt_o = cache_pkt_i[grant];
  assign accept      = cache_v_o & cache_ready_i;
  assign ready_o     = accept ? (2'b01 << grant) : 2'b00;

  assign v_we_o = (reset_n_i & cache_v_we_i) ? (2'b01 << tl_owner_r) : 2'b00;

  assign resp_v       = reset_n_i & cache_v_i & ~empty;
  assign v_o          = resp_v ? (2'b01 << head) : 2'b00;
  assign cache_yumi_o = resp_v & yumi_i[head];
  assign data_o       = cache_data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r     <= 1'b1;
      tl_owner_r <= 1'b0;
    end else if (accept) begin
      last_r     <= grant;
      tl_owner_r <= grant;
    end
  end

  bsg_fifo_1r1w_small #(
    .els_p   (fifo_els_p),
    .width_p ($bits(bsg_cache_arb_id_t))
  ) order_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (accept),
    .data_i    (grant),
    .yumi_i    (cache_yumi_o),
    .data_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding means the cache and arbiter disagree.
  resp_without_req: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(cache_v_i && empty));
`endif

endmodule

// File: tb/tb_bsg_manycore_cache_pkt_arbiter.sv
// tb/tb_bsg_manycore_cache_pkt_arbiter.sv - scoreboard bench for the cache packet arbiter
module tb_bsg_manycore_cache_pkt_arbiter;
  import bsg_manycore_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int ELS = 4;
  localparam int PW  = bsg_cache_pkt_width(AW, DW);

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [1:0][PW-1:0] cache_pkt_i;
  logic [1:0]        v_i, ready_o, v_o, yumi_i, v_we_o;
  logic [DW-1:0]     data_o, cache_data_i;
  logic [PW-1:0]     cache_pkt_o;
  logic              cache_v_o, cache_ready_i, cache_v_i, cache_yumi_o, cache_v_we_i;

  always #5 clk_i = ~clk_i;

  bsg_manycore_cache_pkt_arbiter #(
    .cache_addr_width_p (AW),
    .data_width_p       (DW),
    .fifo_els_p         (ELS)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .cache_pkt_i   (cache_pkt_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .v_o           (v_o),
    .yumi_i        (yumi_i),
    .v_we_o        (v_we_o),
    .cache_pkt_o   (cache_pkt_o),
    .cache_v_o     (cache_v_o),
    .cache_ready_i (cache_ready_i),
    .cache_data_i  (cache_data_i),
    .cache_v_i     (cache_v_i),
    .cache_yumi_o  (cache_yumi_o),
    .cache_v_we_i  (cache_v_we_i)
  );

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } sb_t;

  sb_t  sb_q[$];
  int   tests = 0;
  int   fails = 0;
  logic m_last, m_tl;
  logic e_g, e_cv, e_yumi;
  logic [1:0] e_ready, e_v_o, e_v_we;

  // Reference model of the arbiter outputs for the currently driven inputs.
  task automatic model_eval();
    logic both;
    both = v_i[0] & v_i[1];
`ifdef BSG_MANYCORE_CACHE_ARB_FIXED_PRIO_EN
    e_g = both ? 1'b0 : v_i[1];
`else
    e_g = both ? ~m_last : v_i[1];
`endif
    e_cv    = reset_n_i && (v_i != 2'b00) && (sb_q.size() < ELS);
    e_ready = (e_cv && cache_ready_i) ? (e_g ? 2'b10 : 2'b01) : 2'b00;
    e_v_we  = (reset_n_i && cache_v_we_i) ? (m_tl ? 2'b10 : 2'b01) : 2'b00;
    e_v_o   = (reset_n_i && cache_v_i && sb_q.size() > 0) ? (sb_q[0].id ? 2'b10 : 2'b01) : 2'b00;
    e_yumi  = |(e_v_o & yumi_i);
  endtask

  task automatic drive(input logic [1:0] v, input logic cr, input logic cv,
                       input logic [1:0] y, input logic we);
    logic [63:0] r0, r1;
    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};
    cache_pkt_i[0] = r0[PW-1:0];
    cache_pkt_i[1] = r1[PW-1:0];
    v_i           = v;
    cache_ready_i = cr;
    cache_v_i     = cv && (sb_q.size() > 0);
    cache_data_i  = (sb_q.size() > 0) ? sb_q[0].data : '0;
    yumi_i        = y;
    cache_v_we_i  = we;
    #1;
    model_eval();
  endtask

  task automatic tick();
    sb_t tmp;
    if (e_yumi) tmp = sb_q.pop_front();
    if (|e_ready) begin
      tmp.id   = e_g;
      tmp.data = cache_pkt_i[e_g][DW-1:0] ^ 32'h5a5a_0000;
      sb_q.push_back(tmp);
      m_last = e_g;
      m_tl   = e_g;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    v_i = '0; cache_ready_i = 0; cache_v_i = 0; yumi_i = '0;
    cache_v_we_i = 0; cache_data_i = '0; cache_pkt_i = '0;
    sb_q.delete();
    m_last = 1'b1;
    m_tl   = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    v_i = 2'b11; cache_ready_i = 1; cache_v_i = 1; yumi_i = 2'b11; cache_v_we_i = 1;
    #2;
    tests++;
    if ({ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o} !== 8'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b exp 00000000", {ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o});
    end
    cache_v_i = 0;
    do_reset();
  endtask

  task automatic test_single_client();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(2'b01, 1, 0, 2'b00, 0);
      else       drive(2'b00, 0, 1, 2'b01, 0);
      tests++;
      if ({ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o} !== {e_ready, e_cv, e_v_o, e_yumi, e_v_we}
          || (i >= 3 && (v_o !== 2'b01 || data_o !== sb_q[0].data))) begin
        fails++;
        $display("FAIL single c%0d: rdy/cv/vo/yumi/we got %b exp %b", i,
                 {ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o}, {e_ready, e_cv, e_v_o, e_yumi, e_v_we});
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g_seq;
    g_seq = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1, 0, 2'b00, 0);
      g_seq = {g_seq[2:0], ready_o[1]};
      tick();
    end
    tests++;
`ifdef BSG_MANYCORE_CACHE_ARB_FIXED_PRIO_EN
    if (g_seq !== 4'b0000) begin
      fails++; $display("FAIL rr_grants: got %b exp 0000", g_seq);
    end
`else
    if (g_seq !== 4'b0101) begin
      fails++; $display("FAIL rr_grants: got %b exp 0101", g_seq);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 0, 1, 2'b11, 0);
      tests++;
      if ({v_o, cache_yumi_o} !== {e_v_o, e_yumi} || data_o !== sb_q[0].data) begin
        fails++;
        $display("FAIL rr_resp r%0d: vo/yumi got %b exp %b", i, {v_o, cache_yumi_o}, {e_v_o, e_yumi});
      end
      tick();
    end
  endtask

  task automatic test_full();
    int n_acc;
    n_acc = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1, 0, 2'b00, 0);
      n_acc += int'(ready_o[0]);
      tick();
    end
    tests++;
    if (n_acc != ELS || cache_v_o !== 1'b0) begin
      fails++; $display("FAIL full_accepts: got %0d cv %b exp %0d cv 0", n_acc, cache_v_o, ELS);
    end
    drive(2'b01, 1, 1, 2'b01, 0);
    tests++;
    if ({ready_o, cache_v_o, v_o, cache_yumi_o} !== 6'b00_0_01_1) begin
      fails++; $display("FAIL full_pop_cycle: got %b exp 000011", {ready_o, cache_v_o, v_o, cache_yumi_o});
    end
    tick();
    drive(2'b01, 1, 0, 2'b00, 0);
    tests++;
    if (ready_o !== 2'b01 || ready_o !== e_ready) begin
      fails++; $display("FAIL full_next_accept: got %b exp 01", ready_o);
    end
    tick();
  endtask

  task automatic test_v_we();
    do_reset();
    drive(2'b10, 1, 0, 2'b00, 0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1);
    tests++;
    if (v_we_o !== 2'b10 || v_we_o !== e_v_we) begin
      fails++; $display("FAIL v_we_c1: got %b exp 10", v_we_o);
    end
    tick();
    drive(2'b01, 1, 0, 2'b00, 0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1);
    tests++;
    if (v_we_o !== 2'b01 || v_we_o !== e_v_we) begin
      fails++; $display("FAIL v_we_c0: got %b exp 01", v_we_o);
    end
    tick();
  endtask

  task automatic test_head_block();
    do_reset();
    drive(2'b01, 1, 0, 2'b00, 0);
    tick();
    drive(2'b10, 1, 0, 2'b00, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 0, 1, 2'b10, 0);
      tests++;
      if (v_o !== 2'b01 || cache_yumi_o !== 1'b0 || {v_o, cache_yumi_o} !== {e_v_o, e_yumi}) begin
        fails++; $display("FAIL head_block c%0d: vo/yumi got %b exp 010", i, {v_o, cache_yumi_o});
      end
      tick();
    end
    drive(2'b00, 0, 1, 2'b01, 0);
    tick();
    drive(2'b00, 0, 1, 2'b10, 0);
    tests++;
    if ({v_o, cache_yumi_o} !== 3'b10_1 || data_o !== sb_q[0].data) begin
      fails++; $display("FAIL head_c1_deliver: vo/yumi got %b exp 101", {v_o, cache_yumi_o});
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(2'b11, 1, 0, 2'b00, 0);
    tick();
    drive(2'b11, 1, 0, 2'b00, 0);
    tick();
    drive(2'b11, 1, 1, 2'b00, 1);
    reset_n_i = 1'b0;
    #1;
    tests++;
    if ({ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o} !== 8'b0) begin
      fails++; $display("FAIL midflight_async: got %b exp 00000000", {ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o});
    end
    sb_q.delete();
    m_last = 1'b1;
    m_tl   = 1'b0;
    cache_v_i = 0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    drive(2'b11, 1, 1, 2'b11, 0);
    tests++;
    if (ready_o !== 2'b01 || v_o !== 2'b00 || {ready_o, v_o} !== {e_ready, e_v_o}) begin
      fails++; $display("FAIL midflight_after: rdy/vo got %b exp 0100", {ready_o, v_o});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      tests++;
      if ({ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o} !== {e_ready, e_cv, e_v_o, e_yumi, e_v_we}
          || cache_pkt_o !== cache_pkt_i[e_g]
          || (e_v_o != 2'b00 && data_o !== sb_q[0].data)) begin
        fails++;
        $display("FAIL b2b c%0d: rdy/cv/vo/yumi/we got %b exp %b pkt_ok %b", i,
                 {ready_o, cache_v_o, v_o, cache_yumi_o, v_we_o}, {e_ready, e_cv, e_v_o, e_yumi, e_v_we},
                 cache_pkt_o === cache_pkt_i[e_g]);
      end
      tick();
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    m_last = 1'b1;
    m_tl   = 1'b0;
    test_reset();
    test_single_client();
    test_round_robin();
    test_full();
    test_v_we();
    test_head_block();
    test_reset_midflight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
